// File: rtl/data_fifo_pkg.sv
// data_fifo_pkg: shared pointer-width helper and operation decode type for data_fifo_n.
package data_fifo_pkg;
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction
  typedef enum logic [1:0] {FIFO_IDLE, FIFO_WR, FIFO_RD, FIFO_RW} fifo_op_e;
endpackage

// File: rtl/data_fifo_mem.sv
// data_fifo_mem: DEPTH x N storage, one clocked write port and one asynchronous read port.
module data_fifo_mem #(
  parameter int N     = 16,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          CLK,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [N-1:0]  wd,
  input  logic [AW-1:0] ra,
  output logic [N-1:0]  rd
);
  logic [N-1:0] mem [DEPTH];
  always_ff @(posedge CLK)
    if (we) mem[wa] <= wd;
  assign rd = mem[ra];
endmodule

// File: rtl/data_fifo_n.sv
// data_fifo_n: synchronous first-word-fall-through FIFO of N-bit words.
// Define DATA_FIFO_HWM_EN to add the registered high-water-mark output HWM.
module data_fifo_n
  import data_fifo_pkg::*;
#(
  parameter int N     = 16,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RESETN,
  input  logic                     WR_EN,
  input  logic [N-1:0]             WR_DATA,
  output logic                     FULL,
  input  logic                     RD_EN,
  output logic [N-1:0]             RD_DATA,
  output logic                     EMPTY,
  output logic [ptr_w(DEPTH):0]    COUNT,
  output logic                     OVF,
  output logic                     UNF
`ifdef DATA_FIFO_HWM_EN
  ,
  output logic [ptr_w(DEPTH):0]    HWM
`endif
);
  localparam int AW = ptr_w(DEPTH);
  localparam int CW = AW + 1;
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("data_fifo_n: DEPTH must be a power of 2 and >= 2");
  end
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_nxt;
  logic [N-1:0]  mem_rd;
  logic          wr_ok, rd_ok;
  fifo_op_e      op;
  assign wr_ok = WR_EN && (!FULL || RD_EN);
  assign rd_ok = RD_EN && !EMPTY;
  always_comb begin
    op        = wr_ok ? (rd_ok ? FIFO_RW : FIFO_WR) : (rd_ok ? FIFO_RD : FIFO_IDLE);
    count_nxt = op == FIFO_WR ? COUNT + CW'(1) : op == FIFO_RD ? COUNT - CW'(1) : COUNT;
  end
  data_fifo_mem #(.N(N), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .CLK (CLK),
    .we  (wr_ok && RESETN),
    .wa  (wr_ptr),
    .wd  (WR_DATA),
    .ra  (rd_ptr),
    .rd  (mem_rd)
  );
  // Empty output is held at zero so the downstream register never samples X.
  assign RD_DATA = EMPTY ? '0 : mem_rd;
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      COUNT  <= '0;
      FULL   <= 1'b0;
      EMPTY  <= 1'b1;
      OVF    <= 1'b0;
      UNF    <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr_ok);
      rd_ptr <= rd_ptr + AW'(rd_ok);
      COUNT  <= count_nxt;
      FULL   <= count_nxt == CW'(DEPTH);
      EMPTY  <= count_nxt == '0;
      OVF    <= WR_EN && !wr_ok;
      UNF    <= RD_EN && !rd_ok;
    end
  end
`ifdef DATA_FIFO_HWM_EN
  always_ff @(posedge CLK) begin
    if (!RESETN) HWM <= '0;
    else if (count_nxt > HWM) HWM <= count_nxt;
  end
`endif
endmodule

// File: tb/tb_data_fifo_n.sv
// tb_data_fifo_n: directed and randomized checks of data_fifo_n against a queue-based model.
module tb_data_fifo_n;
  localparam int N     = 16;
  localparam int DEPTH = 4;
  logic         CLK = 1'b0;
  logic         RESETN = 1'b0;
  logic         WR_EN = 1'b0;
  logic         RD_EN = 1'b0;
  logic [N-1:0] WR_DATA = '0;
  logic [N-1:0] RD_DATA;
  logic         FULL, EMPTY, OVF, UNF;
  logic [2:0]   COUNT;
`ifdef DATA_FIFO_HWM_EN
  logic [2:0]   HWM;
`endif
  int n_chk = 0;
  int n_fail = 0;
  logic [N-1:0] q[$];
  bit exp_ovf, exp_unf;
  int exp_hwm;

  data_fifo_n #(.N(N), .DEPTH(DEPTH)) dut (
    .CLK     (CLK),
    .RESETN  (RESETN),
    .WR_EN   (WR_EN),
    .WR_DATA (WR_DATA),
    .FULL    (FULL),
    .RD_EN   (RD_EN),
    .RD_DATA (RD_DATA),
    .EMPTY   (EMPTY),
    .COUNT   (COUNT),
    .OVF     (OVF),
    .UNF     (UNF)
`ifdef DATA_FIFO_HWM_EN
    ,
    .HWM     (HWM)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_count"}, 32'(COUNT), q.size());
    check({tag, "_empty"}, 32'(EMPTY), 32'(q.size() == 0));
    check({tag, "_full"}, 32'(FULL), 32'(q.size() == DEPTH));
    check({tag, "_rd_data"}, 32'(RD_DATA), q.size() != 0 ? 32'(q[0]) : 32'h0);
    check({tag, "_ovf"}, 32'(OVF), 32'(exp_ovf));
    check({tag, "_unf"}, 32'(UNF), 32'(exp_unf));
`ifdef DATA_FIFO_HWM_EN
    check({tag, "_hwm"}, 32'(HWM), exp_hwm);
`endif
  endtask

  task automatic cycle(input string tag, input bit w, input logic [N-1:0] d, input bit r, input bit rn = 1'b1);
    bit wa, ra;
    WR_EN = w; WR_DATA = d; RD_EN = r; RESETN = rn;
    @(posedge CLK);
    if (!rn) begin
      q.delete();
      exp_ovf = 0; exp_unf = 0; exp_hwm = 0;
    end else begin
      wa = w && (q.size() < DEPTH || r);
      ra = r && q.size() > 0;
      if (ra) void'(q.pop_front());
      if (wa) q.push_back(d);
      exp_ovf = w && !wa;
      exp_unf = r && !ra;
      if (q.size() > exp_hwm) exp_hwm = q.size();
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    exp_ovf = 0; exp_unf = 0; exp_hwm = 0;
    cycle("reset", 0, '0, 0, 0);
    check("reset_empty_const", 32'(EMPTY), 32'h1);
    for (int i = 1; i <= 4; i++) cycle("fill", 1, N'(i), 0);
    check("t1_full_const", 32'(FULL), 32'h1);
    check("t1_head_const", 32'(RD_DATA), 32'h0001);
    cycle("ovf", 1, 16'hBEEF, 0);
    check("t2_ovf_const", 32'(OVF), 32'h1);
    cycle("ovf_clear", 0, '0, 0);
    for (int i = 0; i < 4; i++) cycle("drain", 0, '0, 1);
    cycle("unf", 0, '0, 1);
    check("t3_unf_const", 32'(UNF), 32'h1);
    cycle("unf_wr", 1, 16'h1234, 1);
    check("t3_count_const", 32'(COUNT), 32'h1);
    cycle("unf_clear", 0, '0, 1);
    for (int i = 0; i < 4; i++) cycle("refill", 1, N'(16'h0010 + i), 0);
    for (int i = 0; i < 6; i++) cycle("full_rw", 1, 16'h00AA, 1);
    for (int i = 0; i < 4; i++) cycle("drain_rw", 0, '0, 1);
    cycle("rst_mid0", 0, '0, 0, 0);
    for (int i = 0; i < 3; i++) cycle("pre_rst", 1, N'(16'h0100 + i), 0);
    cycle("rst_mid", 1, 16'h0055, 0, 0);
    check("t5_rd_data_const", 32'(RD_DATA), 32'h0);
    cycle("post_rst", 0, '0, 0);
    for (int i = 0; i < 3; i++) cycle("hwm_w", 1, N'(16'h0200 + i), 0);
    for (int i = 0; i < 3; i++) cycle("hwm_r", 0, '0, 1);
    cycle("hwm_w1", 1, 16'h0300, 0);
    cycle("hwm_hold", 0, '0, 0);
    cycle("hwm_rst", 0, '0, 0, 0);
    for (int i = 0; i < 3000; i++)
      cycle("rand", 1'($urandom_range(0, 1)), N'($urandom), 1'($urandom_range(0, 1)),
            $urandom_range(0, 99) != 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
